l2_layer_ctrl: RTL and testbench
================================

Name: l2_layer_ctrl

Overview:
- Sequences one shared pipelined neuron (N inputs, 2-cycle latency, ReLU plus 16-bit saturation) across M output neurons of a dense layer.
- Accepts one input vector per layer through a valid/ready handshake.
- Streams weight/bias rows from a synchronous weight ROM/RAM into the neuron, one row per cycle.
- Tags the neuron output with its neuron index, emits a result stream and pulses done at layer end.

Parameters:
N, 4, inputs per neuron (vector length)
WIDTH, 16, signed data width of x, w, b, y
M, 8, output neurons in the layer (M >= 1)
AW, 3, weight-memory address width; must satisfy 2^AW >= M

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
x_valid  in  1  input vector valid
x_ready  out  1  controller can accept a vector
x_in  in  N*WIDTH  input vector, lane i at [i*WIDTH +: WIDTH]
w_rd_en  out  1  weight-memory read enable
w_addr  out  AW  row address = neuron index
w_rdata  in  N*WIDTH  weight row, valid 1 cycle after w_rd_en
b_rdata  in  WIDTH  bias for the row, valid 1 cycle after w_rd_en
nx  out  N*WIDTH  to neuron x; held x register
nw  out  N*WIDTH  to neuron w; combinational pass of w_rdata
nb  out  WIDTH  to neuron b; combinational pass of b_rdata
ny  in  WIDTH  from neuron y (registered inside neuron)
out_valid  out  1  ny carries a result this cycle
out_idx  out  AW  neuron index of the current result
out_data  out  WIDTH  result; combinational pass of ny
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of layer
max_val  out  WIDTH  argmax value; see Optional Feature
max_idx  out  AW  argmax index; see Optional Feature

Behaviour:
- Reset values: state=IDLE, x register=0, cnt=0, tag pipeline cleared, x_ready=1, w_rd_en=0, w_addr=0, out_valid=0, out_idx=0, busy=0, done=0, max_val=0, max_idx=0.
- The neuron shares the same rst, so both reset together.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - x_ready=1.
  - On x_valid, latch x_in, set cnt=0 and move to ISSUE.
  - Call this acceptance cycle T.
- ISSUE:
  - w_rd_en=1 and w_addr=cnt.
  - cnt increments each cycle.
  - When cnt==M-1 the cycle is the last issue; the next state is DRAIN.
  - Issue occupies exactly M cycles, T+1..T+M, with no gaps.
- Tag pipeline: 3-stage shift of {valid, idx}, covering 1 cycle memory latency plus 2 cycles neuron latency.
  - Stage 0 loads {w_rd_en, w_addr} every cycle.
  - out_valid and out_idx come from stage 2.
  - Result for index k appears in cycle T+4+k, so first out_valid is at T+4 and the last is at T+M+3.
- DRAIN:
  - Remain until the tag pipeline holds no valid entry.
  - Then move to DONE.
- DONE:
  - done=1 for exactly one cycle, in cycle T+M+4.
  - Return to IDLE; x_ready=1 again in the next cycle.
- x_valid outside IDLE is ignored; x_ready=0 in those states.
- The x register is stable from T+1 until the next acceptance.
- The output stream has no backpressure; the consumer must take out_valid every cycle.
- No arithmetic is done here. out_data is exactly ny, which is already in the range 0..0x7FFF.
- Reset asserted mid-layer aborts immediately:
  - No further out_valid and no done.
  - A new vector is accepted only after rst deasserts.
- Edge case M=1: single ISSUE cycle, one result at T+4, done at T+5.

Optional Feature:
Macro: L2_LAYER_CTRL_ARGMAX_EN
- Defined:
  - Track the running maximum of out_data and its out_idx across the layer's results.
  - Comparison is signed greater-than; a tie keeps the earlier (lower) index.
  - The tracker is cleared at acceptance (cycle T).
  - max_val and max_idx are valid, and hold, from the done cycle until the next acceptance.
  - When every result is 0, report max_val=0, max_idx=0.
- Undefined: max_val and max_idx are tied to 0 and no tracking registers exist.

Test Plan:
1. M=8, x={1,2,3,4}, all weights 1, bias row k = k. Expect out_idx 0..7 at T+4..T+11 with out_data = 10+k. Expect done only at T+12 and busy high T+1..T+12.
2. Weights row 3 = all -1, bias 0, x={1,2,3,4}. Expect the idx 3 result = 0 (ReLU); other rows unaffected.
3. x=all 0x7FFF, w=all 0x7FFF, bias 0x7FFF. Expect out_data = 0x7FFF (saturation) for that row, with correct out_idx.
4. Pulse x_valid with a different vector at T+3 and T+10. Expect it ignored, x_ready=0 during busy, and results computed with the original x. A vector presented on the cycle after done is accepted.
5. Assert rst at T+6 for 1 cycle. Expect no out_valid or done afterwards, all outputs at reset values, and a subsequent layer running with full correct timing.
6. ARGMAX_EN defined, results {5,9,2,9,0,1,3,4}. Expect max_val=9, max_idx=1 at done. Undefined: max_val=max_idx=0 throughout.

Source files
------------

// File: rtl/l2_layer_ctrl_if.sv
// Signal bundle between the dense-layer controller and its surroundings: input vector
// handshake, weight-memory read port, shared neuron datapath and the tagged result stream.
interface l2_layer_ctrl_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 3
);

  logic                 x_valid;
  logic                 x_ready;
  logic [N*WIDTH-1:0]   x_in;

  logic                 w_rd_en;
  logic [AW-1:0]        w_addr;
  logic [N*WIDTH-1:0]   w_rdata;
  logic [WIDTH-1:0]     b_rdata;

  logic [N*WIDTH-1:0]   nx;
  logic [N*WIDTH-1:0]   nw;
  logic [WIDTH-1:0]     nb;
  logic [WIDTH-1:0]     ny;

  logic                 out_valid;
  logic [AW-1:0]        out_idx;
  logic [WIDTH-1:0]     out_data;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     max_val;
  logic [AW-1:0]        max_idx;

  // Controller side.
  modport master (
    input  x_valid, x_in, w_rdata, b_rdata, ny,
    output x_ready, w_rd_en, w_addr, nx, nw, nb,
           out_valid, out_idx, out_data, busy, done, max_val, max_idx
  );

  // Environment side: vector source, weight memory, neuron and result consumer.
  modport slave (
    output x_valid, x_in, w_rdata, b_rdata, ny,
    input  x_ready, w_rd_en, w_addr, nx, nw, nb,
           out_valid, out_idx, out_data, busy, done, max_val, max_idx
  );

endinterface

// File: rtl/l2_layer_ctrl.sv
// Dense-layer sequencer: issues M weight rows through one shared 2-cycle neuron and tags results.
// Optional running argmax over the layer's results when L2_LAYER_CTRL_ARGMAX_EN is defined.
module l2_layer_ctrl #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned M     = 8,
  parameter int unsigned AW    = 3
) (
  input  logic            clk,
  input  logic            rst,
  l2_layer_ctrl_if.master ctrl_bus
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

  state_e             r_state;
  state_e             w_state_nxt;

  logic [N*WIDTH-1:0] r_x;
  logic [AW-1:0]      r_cnt;
  logic [2:0]         r_tag_vld;
  logic [AW-1:0]      r_tag_idx [3];

  logic               w_accept;
  logic               w_last_issue;
  logic               w_rd_en;
  logic [AW-1:0]      w_addr;
  logic               w_x_ready;
  logic               w_busy;
  logic               w_done;

  assign w_accept     = (r_state == StIdle) && ctrl_bus.x_valid;
  assign w_last_issue = (r_state == StIssue) && (r_cnt == AW'(M - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (ctrl_bus.x_valid) w_state_nxt = StIssue;
      StIssue: if (w_last_issue)     w_state_nxt = StDrain;
      // Stage 2 empties this cycle, so only the two younger stages decide the exit.
      StDrain: if (!r_tag_vld[0] && !r_tag_vld[1]) w_state_nxt = StDone;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    w_x_ready = 1'b0;
    w_rd_en   = 1'b0;
    w_addr    = '0;
    w_busy    = 1'b1;
    w_done    = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_x_ready = 1'b1;
        w_busy    = 1'b0;
      end
      StIssue: begin
        w_rd_en = 1'b1;
        w_addr  = r_cnt;
      end
      StDrain: ;
      StDone:  w_done = 1'b1;
      default: ;
    endcase
  end

  // Input vector register and row counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x   <= '0;
      r_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_x   <= ctrl_bus.x_in;
        r_cnt <= '0;
      end else if (r_state == StIssue) begin
        r_cnt <= w_last_issue ? '0 : r_cnt + 1'b1;
      end
    end
  end

  // Tag pipeline: memory read latency (1) plus neuron latency (2)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_vld    <= '0;
      r_tag_idx[0] <= '0;
      r_tag_idx[1] <= '0;
      r_tag_idx[2] <= '0;
    end else begin
      r_tag_vld    <= {r_tag_vld[1:0], w_rd_en};
      r_tag_idx[0] <= w_addr;
      r_tag_idx[1] <= r_tag_idx[0];
      r_tag_idx[2] <= r_tag_idx[1];
    end
  end

  assign ctrl_bus.x_ready   = w_x_ready;
  assign ctrl_bus.w_rd_en   = w_rd_en;
  assign ctrl_bus.w_addr    = w_addr;
  assign ctrl_bus.nx        = r_x;
  assign ctrl_bus.nw        = ctrl_bus.w_rdata;
  assign ctrl_bus.nb        = ctrl_bus.b_rdata;
  assign ctrl_bus.out_valid = r_tag_vld[2];
  assign ctrl_bus.out_idx   = r_tag_idx[2];
  assign ctrl_bus.out_data  = ctrl_bus.ny;
  assign ctrl_bus.busy      = w_busy;
  assign ctrl_bus.done      = w_done;

`ifdef L2_LAYER_CTRL_ARGMAX_EN
  logic [WIDTH-1:0] r_max_val;
  logic [AW-1:0]    r_max_idx;

  // Strict greater-than keeps the lowest index on ties.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_max_val <= '0;
      r_max_idx <= '0;
    end else if (w_accept) begin
      r_max_val <= '0;
      r_max_idx <= '0;
    end else if (r_tag_vld[2] && ($signed(ctrl_bus.ny) > $signed(r_max_val))) begin
      r_max_val <= ctrl_bus.ny;
      r_max_idx <= r_tag_idx[2];
    end
  end

  assign ctrl_bus.max_val = r_max_val;
  assign ctrl_bus.max_idx = r_max_idx;
`else
  assign ctrl_bus.max_val = '0;
  assign ctrl_bus.max_idx = '0;
`endif

endmodule

// File: tb/tb_l2_layer_ctrl.sv
// Scoreboard bench for l2_layer_ctrl with a behavioural weight ROM and 2-cycle ReLU neuron.
module tb_l2_layer_ctrl;

  localparam int unsigned N     = 4;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned M     = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned VW    = N * WIDTH;

  typedef struct {
    int idx;
    int data;
    int cyc;
  } res_t;

  typedef struct {
    int cyc;
    int mval;
    int midx;
  } done_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_err;

  res_t  exp_q  [$];
  done_t done_q [$];
  int    exp_d  [M];

  logic [WIDTH-1:0] w_mem [M][N];
  logic [WIDTH-1:0] b_mem [M];
  longint           acc_q;

  l2_layer_ctrl_if #(.N(N), .WIDTH(WIDTH), .AW(AW)) bus_if ();

  l2_layer_ctrl #(.N(N), .WIDTH(WIDTH), .M(M), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .ctrl_bus (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous weight/bias memory, one cycle read latency.
  always @(posedge clk) begin
    if (rst) begin
      bus_if.w_rdata <= '0;
      bus_if.b_rdata <= '0;
    end else if (bus_if.w_rd_en) begin
      for (int i = 0; i < int'(N); i++) begin
        bus_if.w_rdata[i*WIDTH +: WIDTH] <= w_mem[bus_if.w_addr][i];
      end
      bus_if.b_rdata <= b_mem[bus_if.w_addr];
    end
  end

  function automatic longint dot(input logic [VW-1:0] x, input logic [VW-1:0] w,
                                 input logic [WIDTH-1:0] b);
    longint s;
    s = longint'($signed(b));
    for (int i = 0; i < int'(N); i++) begin
      s += longint'($signed(x[i*WIDTH +: WIDTH])) * longint'($signed(w[i*WIDTH +: WIDTH]));
    end
    return s;
  endfunction

  // Neuron: multiply-accumulate stage, then ReLU and 16-bit saturation stage.
  always @(posedge clk) begin
    if (rst) begin
      acc_q     <= 0;
      bus_if.ny <= '0;
    end else begin
      acc_q     <= dot(bus_if.nx, bus_if.nw, bus_if.nb);
      bus_if.ny <= (acc_q < 0) ? '0 : (acc_q > 32767) ? 16'h7FFF : WIDTH'(acc_q);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result or done.
  always @(negedge clk) begin
    res_t  r;
    done_t d;
    if (bus_if.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        r = exp_q.pop_front();
        chk("out_idx", 64'(bus_if.out_idx), 64'(r.idx));
        chk("out_data", 64'(bus_if.out_data), 64'(r.data));
        chk("out_cycle", 64'(cyc), 64'(r.cyc));
      end
    end
    if (bus_if.done) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        d = done_q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(d.cyc));
        chk("max_val", 64'(bus_if.max_val), 64'(d.mval));
        chk("max_idx", 64'(bus_if.max_idx), 64'(d.midx));
      end
    end
  end

  function automatic logic [VW-1:0] pack4(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                          input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
    return {d, c, b, a};
  endfunction

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rom_uniform(input logic [WIDTH-1:0] wv);
    for (int k = 0; k < int'(M); k++) begin
      for (int i = 0; i < int'(N); i++) w_mem[k][i] = wv;
      b_mem[k] = WIDTH'(k);
    end
  endtask

  // Presents a vector and returns the acceptance cycle; ends at #1 into the following cycle.
  task automatic send_vec(input logic [VW-1:0] v, output int t);
    bus_if.x_in    = v;
    bus_if.x_valid = 1'b1;
    t = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus_if.x_ready) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus_if.x_valid = 1'b0;
  endtask

  task automatic push_layer(input int t, input int mval, input int midx);
    res_t  r;
    done_t d;
    for (int k = 0; k < int'(M); k++) begin
      r.idx  = k;
      r.data = exp_d[k];
      r.cyc  = t + 4 + k;
      exp_q.push_back(r);
    end
    d.cyc = t + int'(M) + 4;
`ifdef L2_LAYER_CTRL_ARGMAX_EN
    d.mval = mval;
    d.midx = midx;
`else
    d.mval = 0;
    d.midx = 0;
`endif
    done_q.push_back(d);
  endtask

  task automatic run_layer(input logic [VW-1:0] v, input int mval, input int midx);
    int t;
    send_vec(v, t);
    push_layer(t, mval, midx);
    chk("busy_first_issue", 64'(bus_if.busy), 64'd1);
    chk("x_ready_busy", 64'(bus_if.x_ready), 64'd0);
    goto(t + int'(M) + 4);
    chk("busy_done_cycle", 64'(bus_if.busy), 64'd1);
    goto(t + int'(M) + 5);
    chk("busy_after_done", 64'(bus_if.busy), 64'd0);
    chk("x_ready_after_done", 64'(bus_if.x_ready), 64'd1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_x_ready", 64'(bus_if.x_ready), 64'd1);
    chk("rst_busy", 64'(bus_if.busy), 64'd0);
    chk("rst_done", 64'(bus_if.done), 64'd0);
    chk("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
    chk("rst_w_rd_en", 64'(bus_if.w_rd_en), 64'd0);
    chk("rst_w_addr", 64'(bus_if.w_addr), 64'd0);
    chk("rst_out_idx", 64'(bus_if.out_idx), 64'd0);
    chk("rst_nx", 64'(bus_if.nx), 64'd0);
    chk("rst_max_val", 64'(bus_if.max_val), 64'd0);
    chk("rst_max_idx", 64'(bus_if.max_idx), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int t2;
    n_checks       = 0;
    n_err          = 0;
    rst            = 1'b1;
    bus_if.x_valid = 1'b0;
    bus_if.x_in    = '0;
    rom_uniform(16'd1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_outputs();

    // Unit weights, bias k: result 10 + k.
    for (int k = 0; k < int'(M); k++) exp_d[k] = 10 + k;
    run_layer(pack4(16'd1, 16'd2, 16'd3, 16'd4), 17, 7);

    // Row 3 negative: ReLU clamps it to zero.
    w_mem[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    b_mem[3] = 16'd0;
    exp_d[3] = 0;
    run_layer(pack4(16'd1, 16'd2, 16'd3, 16'd4), 17, 7);

    // Saturation, including a full-scale row and one strongly negative row.
    rom_uniform(16'd1);
    w_mem[5] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    b_mem[5] = 16'h7FFF;
    w_mem[6] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    b_mem[6] = 16'd0;
    for (int k = 0; k < int'(M); k++) exp_d[k] = 32'h7FFF;
    exp_d[6] = 0;
    run_layer(pack4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), 32'h7FFF, 0);

    // Vectors presented while busy are ignored; the cycle after done accepts.
    rom_uniform(16'd1);
    for (int k = 0; k < int'(M); k++) exp_d[k] = 10 + k;
    send_vec(pack4(16'd1, 16'd2, 16'd3, 16'd4), t);
    push_layer(t, 17, 7);
    goto(t + 3);
    bus_if.x_in    = pack4(16'd100, 16'd100, 16'd100, 16'd100);
    bus_if.x_valid = 1'b1;
    chk("x_ready_t3", 64'(bus_if.x_ready), 64'd0);
    goto(t + 4);
    bus_if.x_valid = 1'b0;
    chk("nx_held_t4", 64'(bus_if.nx), 64'(pack4(16'd1, 16'd2, 16'd3, 16'd4)));
    goto(t + 10);
    bus_if.x_valid = 1'b1;
    chk("x_ready_t10", 64'(bus_if.x_ready), 64'd0);
    goto(t + 11);
    bus_if.x_valid = 1'b0;
    chk("nx_held_t11", 64'(bus_if.nx), 64'(pack4(16'd1, 16'd2, 16'd3, 16'd4)));
    goto(t + int'(M) + 5);
    for (int k = 0; k < int'(M); k++) exp_d[k] = 8 + k;
    send_vec(pack4(16'd2, 16'd2, 16'd2, 16'd2), t2);
    chk("accept_after_done", 64'(t2), 64'(t + int'(M) + 5));
    push_layer(t2, 15, 7);
    goto(t2 + int'(M) + 5);

    // Reset mid-layer aborts it; the next layer runs normally.
    for (int k = 0; k < int'(M); k++) exp_d[k] = 10 + k;
    send_vec(pack4(16'd1, 16'd2, 16'd3, 16'd4), t);
    push_layer(t, 17, 7);
    goto(t + 6);
    rst = 1'b1;
    goto(t + 7);
    exp_q.delete();
    done_q.delete();
    rst = 1'b0;
    chk_reset_outputs();
    goto(t + 20);
    run_layer(pack4(16'd1, 16'd2, 16'd3, 16'd4), 17, 7);

    // Result equals bias with a zero vector; argmax tie keeps index 1.
    b_mem = '{16'd5, 16'd9, 16'd2, 16'd9, 16'd0, 16'd1, 16'd3, 16'd4};
    exp_d = '{5, 9, 2, 9, 0, 1, 3, 4};
    run_layer('0, 9, 1);

    // All-zero results report argmax 0 at index 0.
    for (int k = 0; k < int'(M); k++) begin
      b_mem[k] = '0;
      exp_d[k] = 0;
    end
    run_layer('0, 0, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("results_drained", 64'(exp_q.size()), 64'd0);
    chk("dones_drained", 64'(done_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
